// File: rtl/program_loader.sv
// Byte-stream program loader: receives a length-prefixed frame and writes it word by word
// into program memory while holding the CPU in reset. Optional trailing checksum: LOADER_CHECKSUM_EN.
module program_loader #(
    parameter int unsigned MEM_BYTES = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         byte_valid,
    input  logic [7:0]                   byte_data,
    output logic                         byte_ready,
    output logic [$clog2(MEM_BYTES)-1:0] mem_address,
    output logic                         mem_write_enable,
    output logic [31:0]                  mem_write_data,
    output logic                         cpu_hold,
    output logic                         done,
    output logic                         error
);

    localparam int unsigned MEM_WORDS = MEM_BYTES / 4;
    localparam int unsigned AW        = $clog2(MEM_BYTES);

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StData,
        StWrite,
        StDone,
        StError
`ifdef LOADER_CHECKSUM_EN
        ,
        StCheck
`endif
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      len_q;
    logic [AW-1:0]   word_idx_q;
    logic [1:0]      byte_idx_q;
    logic [31:0]     word_buf_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]      sum_q;
`endif

    logic fire;
    logic len_bad;
    logic last_word;

    assign fire      = byte_valid && byte_ready;
    assign len_bad   = (byte_data == 8'd0) || (32'(byte_data) > MEM_WORDS);
    assign last_word = (32'(word_idx_q) == (32'(len_q) - 32'd1));

    // All outputs decode from the state register or come straight from registers.
`ifdef LOADER_CHECKSUM_EN
    assign byte_ready = (state_q == StLen) || (state_q == StData) || (state_q == StCheck);
`else
    assign byte_ready = (state_q == StLen) || (state_q == StData);
`endif
    assign mem_write_enable = (state_q == StWrite);
    assign mem_address      = word_idx_q << 2;
    assign mem_write_data   = word_buf_q;
    assign cpu_hold         = (state_q != StDone);
    assign done             = (state_q == StDone);
    assign error            = (state_q == StError);

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start) state_d = StLen;
            end
            StLen: begin
                if (fire) state_d = len_bad ? StError : StData;
            end
            StData: begin
                if (fire && (byte_idx_q == 2'd3)) state_d = StWrite;
            end
            StWrite: begin
                if (!last_word) begin
                    state_d = StData;
                end else begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = StCheck;
`else
                    state_d = StDone;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            StCheck: begin
                if (fire) state_d = (byte_data == sum_q) ? StDone : StError;
            end
`endif
            StDone, StError: begin
                if (start) state_d = StLen;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_q      <= 8'd0;
            word_idx_q <= '0;
            byte_idx_q <= 2'd0;
            word_buf_q <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= 8'd0;
`endif
        end else begin
            case (state_q)
                StIdle, StDone, StError: begin
                    // A new frame always restarts from address 0 with a clean buffer.
                    if (start) begin
                        word_idx_q <= '0;
                        byte_idx_q <= 2'd0;
                        word_buf_q <= 32'd0;
                    end
                end
                StLen: begin
                    if (fire) begin
                        len_q      <= byte_data;
                        word_idx_q <= '0;
                        byte_idx_q <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
                        sum_q      <= byte_data;
`endif
                    end
                end
                StData: begin
                    if (fire) begin
                        word_buf_q[{byte_idx_q, 3'b000} +: 8] <= byte_data;
                        byte_idx_q <= byte_idx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        sum_q      <= sum_q + byte_data;
`endif
                    end
                end
                StWrite: begin
                    if (!last_word) word_idx_q <= word_idx_q + AW'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: table of single-word frames plus hand-written
// multi-word, reset, reload and error-recovery sequences.
module tb_program_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic [4:0]  mem_address;
    logic        mem_write_enable;
    logic [31:0] mem_write_data;
    logic        cpu_hold;
    logic        done;
    logic        error;

    program_loader #(
        .MEM_BYTES(32)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .byte_valid      (byte_valid),
        .byte_data       (byte_data),
        .byte_ready      (byte_ready),
        .mem_address     (mem_address),
        .mem_write_enable(mem_write_enable),
        .mem_write_data  (mem_write_data),
        .cpu_hold        (cpu_hold),
        .done            (done),
        .error           (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned passed = 0;
    int unsigned total  = 0;
    logic [7:0]  csum;

    logic [4:0]  wr_addr[$];
    logic [31:0] wr_data[$];

    always @(negedge clk) begin
        if (mem_write_enable) begin
            wr_addr.push_back(mem_address);
            wr_data.push_back(mem_write_data);
        end
    end

    typedef struct {
        logic [7:0]  len;
        logic [31:0] bytes;     // first byte sent in bits 31:24
        int          gap;
        logic        exp_err;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_write(input string name, input int idx, input logic [4:0] exp_addr,
                               input logic [31:0] exp_data);
        if (idx < wr_data.size()) begin
            check({name, " addr"}, 32'(wr_addr[idx]), 32'(exp_addr));
            check({name, " data"}, wr_data[idx], exp_data);
        end else begin
            check({name, " present"}, wr_data.size(), idx + 1);
        end
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic ok;
        ok         = 1'b0;
        byte_valid = 1'b1;
        byte_data  = b;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (byte_ready) ok = 1'b1;
        end
        if (ok) begin
            @(posedge clk);
            #1;
            csum = csum + b;
        end else begin
            check("byte_ready timeout", 32'(ok), 32'd1);
        end
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_checksum(input logic [7:0] c);
`ifdef LOADER_CHECKSUM_EN
        send_byte(c, 0);
`else
        if (c == 8'h00) csum = 8'h00;
`endif
    endtask

    task automatic wait_end();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || error) break;
        end
    endtask

    initial begin
        int base;
        reset      = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        csum       = 8'h00;

        vecs[0] = '{8'h01, 32'h13000000, 0, 1'b0, 32'h00000013};
        vecs[1] = '{8'h01, 32'hAABBCCDD, 2, 1'b0, 32'hDDCCBBAA};
        vecs[2] = '{8'h00, 32'h00000000, 0, 1'b1, 32'h00000000};
        vecs[3] = '{8'h09, 32'h00000000, 0, 1'b1, 32'h00000000};
        vecs[4] = '{8'h01, 32'h12345678, 1, 1'b0, 32'h78563412};
        vecs[5] = '{8'hFF, 32'h00000000, 0, 1'b1, 32'h00000000};

        #3;
        check("reset byte_ready", 32'(byte_ready), 32'd0);
        check("reset wen", 32'(mem_write_enable), 32'd0);
        check("reset addr", 32'(mem_address), 32'd0);
        check("reset wdata", mem_write_data, 32'd0);
        check("reset cpu_hold", 32'(cpu_hold), 32'd1);
        check("reset done", 32'(done), 32'd0);
        check("reset error", 32'(error), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Table-driven single-word frames and bad lengths.
        foreach (vecs[i]) begin
            do_reset();
            base = wr_data.size();
            csum = 8'h00;
            pulse_start();
            send_byte(vecs[i].len, vecs[i].gap);
            if (!vecs[i].exp_err) begin
                for (int k = 0; k < 4; k++) send_byte(vecs[i].bytes[31-8*k -: 8], vecs[i].gap);
                send_checksum(csum);
            end
            wait_end();
            check($sformatf("vec%0d done", i), 32'(done), 32'(!vecs[i].exp_err));
            check($sformatf("vec%0d error", i), 32'(error), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d cpu_hold", i), 32'(cpu_hold), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d writes", i), wr_data.size() - base,
                  vecs[i].exp_err ? 32'd0 : 32'd1);
            if (!vecs[i].exp_err) check_write($sformatf("vec%0d w0", i), base, 5'd0,
                                              vecs[i].exp_data);
        end

        // Two words with 3-cycle gaps between bytes.
        do_reset();
        base = wr_data.size();
        csum = 8'h00;
        pulse_start();
        send_byte(8'h02, 3);
        send_byte(8'h13, 3); send_byte(8'h00, 3); send_byte(8'h00, 3); send_byte(8'h00, 3);
        send_byte(8'h93, 3); send_byte(8'h00, 3); send_byte(8'h10, 3); send_byte(8'h00, 3);
        send_checksum(csum);
        wait_end();
        check("gap writes", wr_data.size() - base, 32'd2);
        check_write("gap w0", base, 5'd0, 32'h00000013);
        check_write("gap w1", base + 1, 5'd4, 32'h00100093);
        check("gap done", 32'(done), 32'd1);

        // Reload from DONE; a stray start mid-frame must be ignored.
        base = wr_data.size();
        csum = 8'h00;
        pulse_start();
        check("reload done drop", 32'(done), 32'd0);
        check("reload cpu_hold", 32'(cpu_hold), 32'd1);
        send_byte(8'h01, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        pulse_start();
        send_byte(8'hCC, 0);
        send_byte(8'hDD, 0);
        send_checksum(csum);
        wait_end();
        check("reload writes", wr_data.size() - base, 32'd1);
        check_write("reload w0", base, 5'd0, 32'hDDCCBBAA);
        check("reload done", 32'(done), 32'd1);

        // Maximum length: eight words, last address 28.
        do_reset();
        base = wr_data.size();
        csum = 8'h00;
        pulse_start();
        send_byte(8'h08, 0);
        for (int w = 0; w < 8; w++)
            for (int k = 0; k < 4; k++) send_byte(8'(16 * w + k + 1), 0);
        send_checksum(csum);
        wait_end();
        check("max writes", wr_data.size() - base, 32'd8);
        for (int w = 0; w < 8; w++)
            check_write($sformatf("max w%0d", w), base + w, 5'(4 * w),
                        {8'(16 * w + 4), 8'(16 * w + 3), 8'(16 * w + 2), 8'(16 * w + 1)});
        check("max done", 32'(done), 32'd1);

        // Asynchronous reset after the 2nd data byte of word 0.
        do_reset();
        base = wr_data.size();
        csum = 8'h00;
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        #2 reset = 1'b1;
        #1;
        check("midrst byte_ready", 32'(byte_ready), 32'd0);
        check("midrst wen", 32'(mem_write_enable), 32'd0);
        check("midrst addr", 32'(mem_address), 32'd0);
        check("midrst wdata", mem_write_data, 32'd0);
        check("midrst cpu_hold", 32'(cpu_hold), 32'd1);
        check("midrst done", 32'(done), 32'd0);
        check("midrst error", 32'(error), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midrst no writes", wr_data.size() - base, 32'd0);
        csum = 8'h00;
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0); send_byte(8'h04, 0);
        send_checksum(csum);
        wait_end();
        check("midrst writes", wr_data.size() - base, 32'd1);
        check_write("midrst w0", base, 5'd0, 32'h04030201);
        check("midrst done", 32'(done), 32'd1);

        // Error recovery: bad length, then start clears error and a good frame loads.
        do_reset();
        base = wr_data.size();
        csum = 8'h00;
        pulse_start();
        send_byte(8'h00, 0);
        wait_end();
        check("err error", 32'(error), 32'd1);
        pulse_start();
        check("err cleared", 32'(error), 32'd0);
        check("err cpu_hold", 32'(cpu_hold), 32'd1);
        csum = 8'h00;
        send_byte(8'h01, 0);
        send_byte(8'h67, 0); send_byte(8'h45, 0); send_byte(8'h23, 0); send_byte(8'h01, 0);
        send_checksum(csum);
        wait_end();
        check("err recover done", 32'(done), 32'd1);
        check_write("err recover w0", base, 5'd0, 32'h01234567);

`ifdef LOADER_CHECKSUM_EN
        // Good checksum 0x14, bad checksum 0x15.
        do_reset();
        base = wr_data.size();
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h13, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        send_byte(8'h14, 0);
        wait_end();
        check("csum good done", 32'(done), 32'd1);
        do_reset();
        base = wr_data.size();
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h13, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        send_byte(8'h15, 0);
        wait_end();
        check("csum bad error", 32'(error), 32'd1);
        check("csum bad cpu_hold", 32'(cpu_hold), 32'd1);
        check_write("csum bad w0", base, 5'd0, 32'h00000013);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
